// File: rtl/vregfile_pkg.sv
// Shared types, defaults and the lane-merge helper
// for the lane-masked vector register file.
package vregfile_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_LANE_W = 8;

   // Widest register the merge helper can serve
   localparam int MERGE_W = 1024;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } vrf_state_t;

   // mask is bit-granular: lane bits already expanded
   function automatic logic [MERGE_W-1:0] lane_merge(
      input logic [MERGE_W-1:0] old_v,
      input logic [MERGE_W-1:0] new_v,
      input logic [MERGE_W-1:0] mask
   );
      return (old_v & ~mask) | (new_v & mask);
   endfunction

endpackage

// File: rtl/vregfile_lanes_if.sv
// Write, read, reserve and clear signals of the
// vector register file.
interface vregfile_lanes_if
   import vregfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LANE_W = DEF_LANE_W
);
   localparam int NLANE = DATA_W / LANE_W;

   logic              D_EN;
   logic [ADDR_W-1:0] D_Addr;
   logic [DATA_W-1:0] D;
   logic [NLANE-1:0]  D_LMASK;
   logic [ADDR_W-1:0] S_Addr;
   logic [ADDR_W-1:0] T_Addr;
   logic [DATA_W-1:0] S;
   logic [DATA_W-1:0] T;
   logic [DATA_W-1:0] DOUT;
   logic              RSV_EN;
   logic [ADDR_W-1:0] RSV_Addr;
   logic              PEND_S;
   logic              PEND_T;
   logic              CLR_REQ;
   logic              BUSY;

   modport master (
      output D_EN, D_Addr, D, D_LMASK,
      output S_Addr, T_Addr,
      output RSV_EN, RSV_Addr, CLR_REQ,
      input  S, T, DOUT,
      input  PEND_S, PEND_T, BUSY
   );

   modport slave (
      input  D_EN, D_Addr, D, D_LMASK,
      input  S_Addr, T_Addr,
      input  RSV_EN, RSV_Addr, CLR_REQ,
      output S, T, DOUT,
      output PEND_S, PEND_T, BUSY
   );

endinterface

// File: rtl/vreg_scoreboard.sv
// Per-register pending bits: reserve at issue,
// release at writeback, bulk clear.
module vreg_scoreboard
   import vregfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              clr,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              rel_en,
   input  logic [ADDR_W-1:0] rel_addr,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [ADDR_W-1:0] t_addr,
   output logic              pend_s,
   output logic              pend_t
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] pend;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         pend <= '0;
      end else if (clr) begin
         pend <= '0;
      end else begin
         if (rel_en)
            pend[rel_addr] <= 1'b0;
         // a new reservation supersedes a same-cycle release
         if (set_en)
            pend[set_addr] <= 1'b1;
      end
   end

   assign pend_s = pend[s_addr];
   assign pend_t = pend[t_addr];

endmodule

// File: rtl/vregfile_lanes.sv
// Lane-masked vector register file with write bypass,
// pending scoreboard and a sequential clear engine.
module vregfile_lanes
   import vregfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LANE_W = DEF_LANE_W
) (
   input logic             CLK,
   input logic             RESET,
   vregfile_lanes_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NLANE = DATA_W / LANE_W;

   if ((DATA_W % LANE_W) != 0) begin : g_lane_chk
      $error("vregfile_lanes: DATA_W must be a multiple of LANE_W");
   end
   if (DATA_W > MERGE_W) begin : g_width_chk
      $error("vregfile_lanes: DATA_W exceeds MERGE_W");
   end

   vrf_state_t        state;
   logic [ADDR_W-1:0] clr_idx;
   logic [DATA_W-1:0] regs [DEPTH];

   logic              busy;
   logic              wr_en;
   logic              rsv_en;
   logic              clr_go;
   logic              p_s;
   logic              p_t;
   logic [DATA_W-1:0] lane_bits;
   logic [DATA_W-1:0] old_d;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] s_raw;
   logic [DATA_W-1:0] t_raw;

   for (genvar g = 0; g < NLANE; g++) begin : g_lane
      assign lane_bits[g*LANE_W +: LANE_W] = {LANE_W{bus.D_LMASK[g]}};
   end

   assign busy   = (state == CLEAR);
   assign wr_en  = bus.D_EN & ~busy;
   assign rsv_en = bus.RSV_EN & ~busy;
   assign clr_go = bus.CLR_REQ & ~busy;

   assign old_d  = regs[bus.D_Addr];
   assign merged = DATA_W'(lane_merge(MERGE_W'(old_d),
                                      MERGE_W'(bus.D),
                                      MERGE_W'(lane_bits)));

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.CLR_REQ) begin
                  state   <= CLEAR;
                  clr_idx <= '0;
               end
            end
            CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == ADDR_W'(DEPTH - 1))
                  state <= IDLE;
            end
         endcase
      end
   end

   // Storage carries no reset; the clear engine zeroes it
   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (busy)
            regs[clr_idx] <= '0;
         else if (wr_en)
            regs[bus.D_Addr] <= merged;
      end
   end

   assign s_raw = (wr_en && bus.S_Addr == bus.D_Addr) ?
                  merged : regs[bus.S_Addr];
   assign t_raw = (wr_en && bus.T_Addr == bus.D_Addr) ?
                  merged : regs[bus.T_Addr];

   assign bus.S    = busy ? '0 : s_raw;
   assign bus.T    = busy ? '0 : t_raw;
   assign bus.DOUT = busy ? '0 : old_d;
   assign bus.BUSY = busy;

   vreg_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .CLK      (CLK),
      .RESET    (RESET),
      .clr      (clr_go),
      .set_en   (rsv_en),
      .set_addr (bus.RSV_Addr),
      .rel_en   (wr_en),
      .rel_addr (bus.D_Addr),
      .s_addr   (bus.S_Addr),
      .t_addr   (bus.T_Addr),
      .pend_s   (p_s),
      .pend_t   (p_t)
   );

   assign bus.PEND_S = p_s & ~busy;
   assign bus.PEND_T = p_t & ~busy;

endmodule

// File: tb/tb_vregfile_lanes.sv
// Directed and randomized checks of vregfile_lanes
// against a behavioural register-file model.
module tb_vregfile_lanes;
   import vregfile_pkg::*;

   localparam int DW    = 64;
   localparam int AW    = 5;
   localparam int LW    = 8;
   localparam int DEPTH = 32;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;

   vregfile_lanes_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) bus ();

   vregfile_lanes #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .LANE_W (LW)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [63:0]      m_mem [DEPTH];
   logic [DEPTH-1:0] m_pend;
   int               m_rem = 0;
   bit               m_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mmerge(input logic [63:0] o,
                                          input logic [63:0] n,
                                          input logic [7:0]  m);
      logic [63:0] r;
      r = o;
      for (int l = 0; l < 8; l++)
         if (m[l]) r[l*8 +: 8] = n[l*8 +: 8];
      return r;
   endfunction

   // Reference model: remaining clear cycles, contents, pending set
   always @(posedge CLK) begin
      if (!RESET) begin
         m_rem   = DEPTH;
         m_pend  = '0;
         m_valid = 1'b1;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0)
            foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
         if (bus.D_EN) begin
            m_mem[bus.D_Addr] = mmerge(m_mem[bus.D_Addr], bus.D, bus.D_LMASK);
            m_pend[bus.D_Addr] = 1'b0;
         end
         if (bus.RSV_EN)
            m_pend[bus.RSV_Addr] = 1'b1;
         if (bus.CLR_REQ) begin
            m_pend = '0;
            m_rem  = DEPTH;
         end
      end
   end

   always @(negedge CLK) begin : cmp
      logic        busy;
      logic [63:0] es, et, ed;
      if (m_valid) begin
         busy = (m_rem > 0);
         ed = busy ? 64'h0 : m_mem[bus.D_Addr];
         es = m_mem[bus.S_Addr];
         et = m_mem[bus.T_Addr];
         if (bus.D_EN && bus.S_Addr == bus.D_Addr)
            es = mmerge(ed, bus.D, bus.D_LMASK);
         if (bus.D_EN && bus.T_Addr == bus.D_Addr)
            et = mmerge(ed, bus.D, bus.D_LMASK);
         if (busy) begin
            es = '0;
            et = '0;
         end
         chk("cyc_BUSY", 64'(bus.BUSY), 64'(busy));
         chk("cyc_S", bus.S, es);
         chk("cyc_T", bus.T, et);
         chk("cyc_DOUT", bus.DOUT, ed);
         chk("cyc_PEND_S", 64'(bus.PEND_S),
             64'(!busy && m_pend[bus.S_Addr]));
         chk("cyc_PEND_T", 64'(bus.PEND_T),
             64'(!busy && m_pend[bus.T_Addr]));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic set_idle();
      bus.D_EN     = 1'b0;
      bus.D_Addr   = '0;
      bus.D        = '0;
      bus.D_LMASK  = '0;
      bus.RSV_EN   = 1'b0;
      bus.RSV_Addr = '0;
      bus.CLR_REQ  = 1'b0;
   endtask

   // Counts cycles with BUSY high while keeping current inputs
   task automatic count_busy(output int n, input int clr_at);
      n = 0;
      #1;
      while (bus.BUSY === 1'b1 && n < 100) begin
         n++;
         bus.CLR_REQ = (n == clr_at);
         tick();
         #1;
      end
   endtask

   int n;

   initial begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_pend = '0;
      set_idle();
      bus.S_Addr = '0;
      bus.T_Addr = '0;

      // reset then idle
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_BUSY", 64'(bus.BUSY), 64'd1);
      chk("rst_S", bus.S, 64'h0);
      chk("rst_PEND_S", 64'(bus.PEND_S), 64'd0);
      #1;
      RESET = 1'b1;
      count_busy(n, 0);
      chk("rst_busy_len", 64'(n), 64'd32);
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         bus.S_Addr = AW'(i);
         bus.T_Addr = AW'(DEPTH - 1 - i);
         #1;
         chk("rst_zero_S", bus.S, 64'h0);
         chk("rst_zero_T", bus.T, 64'h0);
         tick();
      end

      // masked write
      bus.D_EN    = 1'b1;
      bus.D_Addr  = 5'd3;
      bus.D       = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.D_LMASK = 8'hFF;
      tick();
      bus.D       = 64'h1122_3344_5566_7788;
      bus.D_LMASK = 8'b0000_0101;
      tick();
      set_idle();
      bus.S_Addr = 5'd3;
      bus.T_Addr = 5'd3;
      #1;
      chk("masked_write", bus.S, 64'hFFFF_FFFF_FF66_FF88);
      chk("model_r3", m_mem[3], 64'hFFFF_FFFF_FF66_FF88);

      // bypass
      bus.D_EN    = 1'b1;
      bus.D_Addr  = 5'd3;
      bus.D       = 64'h0;
      bus.D_LMASK = 8'hF0;
      #1;
      chk("bypass_S", bus.S, 64'h0000_0000_FF66_FF88);
      chk("bypass_T", bus.T, 64'h0000_0000_FF66_FF88);
      chk("bypass_DOUT", bus.DOUT, 64'hFFFF_FFFF_FF66_FF88);
      tick();
      set_idle();
      #1;
      chk("bypass_stored", bus.S, 64'h0000_0000_FF66_FF88);

      // scoreboard
      bus.S_Addr   = 5'd7;
      bus.RSV_EN   = 1'b1;
      bus.RSV_Addr = 5'd7;
      #1;
      chk("sb_no_rsv_bypass", 64'(bus.PEND_S), 64'd0);
      tick();
      bus.D_EN     = 1'b1;
      bus.D_Addr   = 5'd7;
      bus.D        = 64'h0123_4567_89AB_CDEF;
      bus.D_LMASK  = 8'hFF;
      #1;
      chk("sb_reserved", 64'(bus.PEND_S), 64'd1);
      tick();
      set_idle();
      #1;
      chk("sb_set_wins", 64'(bus.PEND_S), 64'd1);
      bus.D_EN    = 1'b1;
      bus.D_Addr  = 5'd7;
      bus.D       = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.D_LMASK = 8'h00;
      #1;
      chk("sb_no_rel_bypass", 64'(bus.PEND_S), 64'd1);
      tick();
      set_idle();
      #1;
      chk("sb_released", 64'(bus.PEND_S), 64'd0);
      chk("sb_mask0_hold", bus.S, 64'h0123_4567_89AB_CDEF);

      // clear request with same-cycle write; writes during BUSY dropped
      bus.RSV_EN   = 1'b1;
      bus.RSV_Addr = 5'd9;
      tick();
      set_idle();
      bus.CLR_REQ = 1'b1;
      bus.D_EN    = 1'b1;
      bus.D_Addr  = 5'd31;
      bus.D       = 64'hAA;
      bus.D_LMASK = 8'hFF;
      tick();
      bus.CLR_REQ  = 1'b0;
      bus.D_Addr   = 5'd5;
      bus.D        = {$urandom, $urandom};
      bus.RSV_EN   = 1'b1;
      bus.RSV_Addr = 5'd6;
      count_busy(n, 10);
      chk("clr_busy_len", 64'(n), 64'd32);
      set_idle();
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         bus.S_Addr = AW'(i);
         bus.T_Addr = AW'(i);
         #1;
         chk("clr_data", bus.S, 64'h0);
         chk("clr_pend", 64'(bus.PEND_T), 64'd0);
         tick();
      end

      // reset mid-clear at index 20
      bus.CLR_REQ = 1'b1;
      tick();
      set_idle();
      repeat (20) tick();
      RESET = 1'b0;
      #1;
      chk("midrst_BUSY", 64'(bus.BUSY), 64'd1);
      tick();
      RESET = 1'b1;
      count_busy(n, 0);
      chk("midrst_busy_len", 64'(n), 64'd32);
      tick();

      // randomized traffic checked every cycle by the compare process
      for (int k = 0; k < 3000; k++) begin
         RESET        = ($urandom_range(0, 999) != 0);
         bus.D_EN     = $urandom_range(0, 1) == 1;
         bus.D_Addr   = AW'($urandom_range(0, 31));
         bus.D        = {$urandom, $urandom};
         bus.D_LMASK  = 8'($urandom);
         bus.S_Addr   = ($urandom_range(0, 2) == 0) ?
                        bus.D_Addr : AW'($urandom_range(0, 31));
         bus.T_Addr   = ($urandom_range(0, 2) == 0) ?
                        bus.D_Addr : AW'($urandom_range(0, 31));
         bus.RSV_EN   = ($urandom_range(0, 2) == 0);
         bus.RSV_Addr = ($urandom_range(0, 3) == 0) ?
                        bus.D_Addr : AW'($urandom_range(0, 31));
         bus.CLR_REQ  = ($urandom_range(0, 299) == 0);
         tick();
      end
      RESET = 1'b1;
      set_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vregfile_lanes.md
# vregfile_lanes

Parametrised vector register file for the GBRAINS enhanced datapath: the next generation of the 64-bit vector register file. It is generalised in data width, depth and lane size. It adds per-lane write masking, same-cycle write-to-read bypass, a per-register pending scoreboard for the issue stage, and a sequential clear engine that zeroes storage after reset or on request. It sits between decode/issue (read and reserve) and writeback (write and release).

## Interface
- DATA_W, 64, register width in bits; must be a multiple of LANE_W.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- LANE_W, 8, lane width in bits; NLANE = DATA_W/LANE_W.
- CLK  in  1  sole clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- D_EN  in  1  write enable.
- D_Addr  in  ADDR_W  write / DOUT address.
- D  in  DATA_W  write data.
- D_LMASK  in  NLANE  lane write mask; bit i enables D[i*LANE_W +: LANE_W].
- S_Addr, T_Addr  in  ADDR_W  read port addresses.
- S, T  out  DATA_W  read data, combinational.
- DOUT  out  DATA_W  pre-write contents of D_Addr, combinational, no bypass.
- RSV_EN  in  1  mark register RSV_Addr pending.
- RSV_Addr  in  ADDR_W  reservation address.
- PEND_S, PEND_T  out  1  pending bit of S_Addr / T_Addr.
- CLR_REQ  in  1  request full clear of storage and scoreboard.
- BUSY  out  1  clear engine active.

## Operation
- FSM states: IDLE and CLEAR.
  - RESET low: state goes to CLEAR, clear index is 0, all pending bits are 0.
  - CLEAR: one register is zeroed per cycle at the clear index, and the index increments. After index DEPTH-1 is zeroed, the FSM returns to IDLE.
  - IDLE with CLR_REQ=1: pending bits are cleared, index is 0, state goes to CLEAR next cycle.
  - CLR_REQ is ignored while BUSY.
- BUSY = (state == CLEAR).
- While BUSY:
  - S, T and DOUT read 0.
  - PEND_S and PEND_T read 0.
  - D_EN and RSV_EN are dropped, with no storage or scoreboard effect.
- Write in IDLE: lanes of registers[D_Addr] with D_LMASK=1 take D. Other lanes hold.
  - D_LMASK=0 with D_EN=1 writes no data but still releases the pending bit.
- Bypass in IDLE: if D_EN=1 and S_Addr==D_Addr, then S returns the merged value (new lanes from D, old lanes from storage). T behaves the same way. DOUT always returns the stored pre-write value.
- Scoreboard:
  - pend[RSV_Addr] is set on RSV_EN.
  - pend[D_Addr] is cleared on D_EN.
  - Same address, same cycle: set wins, because a new reservation supersedes the release.
  - PEND_S/PEND_T reflect registered bits only; there is no bypass of same-cycle RSV or release.
- CLR_REQ and D_EN in the same IDLE cycle: the write is performed and the clear starts next cycle, so the clear overwrites it.
- Lane mask width is fixed by parameters. DATA_W not a multiple of LANE_W is illegal and must be caught by an elaboration check.

## Timing
- Reads (S, T, DOUT, PEND_*): zero-cycle combinational from addresses and current state.
- Write: visible in storage one edge after D_EN; visible same cycle through bypass.
- Clear: BUSY high exactly DEPTH cycles, from the first edge after RESET deasserts or after CLR_REQ acceptance. The first usable write is in the cycle BUSY is observed low.
- Reset values: BUSY=1; S=T=DOUT=0; PEND_S=PEND_T=0.
- RESET low mid-clear: the clear restarts at index 0 and BUSY remains high.

## Structure
- Shared package vregfile_pkg holds:
  - default DATA_W, ADDR_W, LANE_W;
  - the FSM state typedef (IDLE, CLEAR);
  - a lane-merge function (old, new, mask), used by both write and bypass.
- One sub-module: vreg_scoreboard, which holds the DEPTH-bit pending vector with the set/clear/priority rules and the two read taps.
- Storage, clear FSM and bypass stay in the top.

## Test plan
- Reset then idle:
  - Stimulus: RESET low 2 cycles, then high.
  - Required: BUSY high for exactly 32 cycles; afterwards S/T read 0 for all 32 addresses.
- Masked write:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF to r3; then D=0x1122_3344_5566_7788 with D_LMASK=8'b0000_0101.
  - Required: r3 = 0xFFFF_FFFF_FF66_FF88.
- Bypass:
  - Stimulus: with r3 as above, D_EN to r3, D=0, D_LMASK=8'hF0, S_Addr=T_Addr=3.
  - Required: S=T=0x0000_0000_FF66_FF88 in the same cycle, while DOUT shows the old value 0xFFFF_FFFF_FF66_FF88.
- Scoreboard:
  - Stimulus: RSV r7; next cycle, D_EN r7 together with RSV_EN r7.
  - Required: PEND_S (S_Addr=7) remains 1.
  - Stimulus: a further D_EN r7 alone.
  - Required: PEND_S = 0 one cycle later.
- Clear request:
  - Stimulus: CLR_REQ with a same-cycle write of 0xAA to r31.
  - Required: writes during BUSY are dropped; after 32 cycles r31=0 and all pending bits are 0.
  - Stimulus: a second CLR_REQ mid-clear.
  - Required: it is ignored.
- Reset mid-clear:
  - Stimulus: RESET low at clear index 20.
  - Required: BUSY stays high and drops exactly 32 cycles after RESET returns high.
